// File: rtl/transaction_ctrl_fsm.sv
// Purpose: transaction-layer control FSM (RESET/INIT/IDLE/ACTIVE/ERROR) with threshold hold and per-channel pause.
// Latency: idle/error/estado decode the state register directly; pause is registered one cycle behind almost-full.
// Backpressure: consumes none; pause is the backpressure this block drives towards the channel sources.
module transaction_ctrl_fsm #(
  parameter int N_CH       = 10,
  parameter int THR_W      = 3,
  parameter int DEF_THR_HI = 6,
  parameter int DEF_THR_LO = 2,
  parameter int IDLE_DLY   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic [THR_W-1:0] umbral_alto,
  input  logic [THR_W-1:0] umbral_bajo,
  input  logic [N_CH-1:0]  fifo_empty,
  input  logic [N_CH-1:0]  fifo_almost_full,
  output logic             idle,
  output logic             error,
  output logic [2:0]       estado,
  output logic [THR_W-1:0] interno_alto,
  output logic [THR_W-1:0] interno_bajo,
  output logic [N_CH-1:0]  pause
);

  // Empty-run counter only has to reach IDLE_DLY, so it is sized to hold exactly that value.
  localparam int CW = (IDLE_DLY < 1) ? 1 : $clog2(IDLE_DLY + 1);
  localparam logic [CW-1:0]    DLY_V    = CW'(IDLE_DLY);
  localparam logic [THR_W-1:0] DEF_HI_V = THR_W'(DEF_THR_HI);
  localparam logic [THR_W-1:0] DEF_LO_V = THR_W'(DEF_THR_LO);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  // Kept as a plain 3-bit vector so the unused codes 5-7 are representable and recoverable.
  logic [2:0]    state_q;
  state_t        state_nxt;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;
  logic          all_empty;
  logic          thr_ok;
  logic          thr_load;

  assign all_empty = &fifo_empty;
  assign thr_ok    = (umbral_bajo < umbral_alto);
  // Saturating increment: once the run length hits IDLE_DLY it stays there.
  assign cnt_inc   = (cnt_q == DLY_V) ? cnt_q : cnt_q + CW'(1);

  // Next-state selection; init overrides every legal state except RESET.
  always_comb begin
    state_nxt = ST_RESET;
    thr_load  = 1'b0;
    case (state_q)
      ST_RESET: begin
        state_nxt = ST_INIT;
      end
      ST_INIT: begin
        if (init) begin
          state_nxt = ST_INIT;
        end else if (thr_ok) begin
          state_nxt = ST_IDLE;
          thr_load  = 1'b1;
        end else begin
          state_nxt = ST_ERROR;
        end
      end
      ST_IDLE: begin
        if (init) begin
          state_nxt = ST_INIT;
        end else if (all_empty) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (init) begin
          state_nxt = ST_INIT;
        end else if (all_empty && (cnt_inc == DLY_V)) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_ACTIVE;
        end
      end
      ST_ERROR: begin
        if (init) begin
          state_nxt = ST_INIT;
        end else begin
          state_nxt = ST_ERROR;
        end
      end
      default: begin
        state_nxt = ST_RESET;
      end
    endcase
  end

  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Thresholds move only on reset or on a successful INIT exit.
  always_ff @(posedge clk) begin
    if (reset) begin
      interno_alto <= DEF_HI_V;
      interno_bajo <= DEF_LO_V;
    end else if (thr_load) begin
      interno_alto <= umbral_alto;
      interno_bajo <= umbral_bajo;
    end
  end

  // Empty-run counter counts consecutive all-empty cycles while ACTIVE, cleared elsewhere.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if ((state_q == ST_ACTIVE) && all_empty) begin
      cnt_q <= cnt_inc;
    end else begin
      cnt_q <= '0;
    end
  end

  // Pause follows almost-full one cycle later, only while the FSM is ACTIVE.
  always_ff @(posedge clk) begin
    if (reset) begin
      pause <= '0;
    end else if (state_q == ST_ACTIVE) begin
      pause <= fifo_almost_full;
    end else begin
      pause <= '0;
    end
  end

  // Status outputs are straight decodes of the state flops, hence glitch-free.
  assign estado = state_q;
  assign idle   = (state_q == ST_IDLE);
  assign error  = (state_q == ST_ERROR);

endmodule
